// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU pipeline definitions used by the forwarding/hazard unit.
//   DEF_REG_AW  : default register address width
//   REG_AW_MAX  : widest register tag the slot record can carry
//   FWD_SEL_RF  : forward-select value meaning "use the register-file value"
//   tag_t       : register tag as stored in the scoreboard (zero-extended)
//   slot_t      : one scoreboard slot (valid, wr, load, dst)
//   slot_hits() : true when a slot holds a live writer of a non-zero tag
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned REG_AW_MAX = 8;
    localparam int unsigned FWD_SEL_RF = 0;

    typedef logic [REG_AW_MAX-1:0] tag_t;

    typedef struct packed {
        logic valid;
        logic wr;
        logic load;
        tag_t dst;
    } slot_t;

    // Tag 0 is the hard-wired zero register: it never matches a producer.
    function automatic logic slot_hits(input slot_t s, input tag_t t);
        return s.valid && s.wr && (t != '0) && (s.dst == t);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Combinational priority encoder for one EX operand: compares the operand tag
// against scoreboard slots 1..NSTAGE-1 and returns the index of the youngest
// (lowest-numbered) live producer, or FWD_SEL_RF when none matches or slot 0
// (the EX instruction itself) is invalid.
// Ports:
//   src_i   : registered source tag of the EX operand
//   slots_i : full scoreboard, slot 0 = EX
//   sel_o   : forward select (0 = register file, j = slot j)
// -----------------------------------------------------------------------------
module fwd_match
    import cpu_pkg::*;
#(
    parameter int unsigned NSTAGE     = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = $clog2(NSTAGE)
) (
    input  tag_t             src_i,
    input  slot_t            slots_i [NSTAGE],
    output logic [SEL_W-1:0] sel_o
);

    logic hit;

    always_comb begin
        sel_o = SEL_W'(FWD_SEL_RF);
        hit   = 1'b0;
        if (slots_i[0].valid) begin
            for (int unsigned j = 1; j < NSTAGE; j++) begin
                // Load data is not yet available below LOAD_READY; such a
                // slot is skipped rather than selected.
                if (!hit && slot_hits(slots_i[j], src_i) &&
                    !(slots_i[j].load && (j < LOAD_READY))) begin
                    sel_o = SEL_W'(j);
                    hit   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard unit between ID and the EX operand muxes.
// Keeps a scoreboard of in-flight destinations (slot 0 = EX, slot 1 = MEM,
// slot NSTAGE-1 = WB), registers the EX source tags, drives per-operand
// forward selects and raises a load-use stall that inserts bubbles.
// Optional feature macro: FWD_PERF_CNT_EN adds a 32-bit stall-cycle counter.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   id_valid         : ID holds a real instruction
//   id_src           : ID source tags, operand 0 in LSBs
//   id_dst           : ID destination tag
//   id_regwrite      : ID instruction writes id_dst
//   id_is_load       : ID instruction is a load
//   hold             : global freeze, no slot changes
//   flush            : squash the instruction advancing into EX
//   stall            : load-use hazard, bubble enters EX
//   fwd_sel          : per-operand forward select, operand 0 in LSBs
//   perf_stall_cnt   : stall-cycle counter (FWD_PERF_CNT_EN only)
// REG_AW must not exceed cpu_pkg::REG_AW_MAX.
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_AW     = DEF_REG_AW,
    parameter int unsigned NSTAGE     = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = $clog2(NSTAGE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      hold,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]               perf_stall_cnt
`endif
);

    slot_t slot_q [NSTAGE];
    slot_t slot_d [NSTAGE];
    tag_t  src_q  [NUM_SRC];
    tag_t  src_d  [NUM_SRC];
    tag_t  id_tag [NUM_SRC];

    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            id_tag[k] = tag_t'(id_src[k*REG_AW +: REG_AW]);
        end
    end

    // Load-use hazard: a load that will not have reached LOAD_READY by the
    // time the ID instruction sits in EX must hold ID.
    always_comb begin
        stall = 1'b0;
        if (id_valid) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                for (int unsigned j = 0; j + 1 < LOAD_READY; j++) begin
                    if (slot_q[j].load && slot_hits(slot_q[j], id_tag[k])) begin
                        stall = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard next state: shift on advance, bubble on stall or flush.
    always_comb begin
        slot_d = slot_q;
        src_d  = src_q;
        if (!hold) begin
            for (int unsigned j = 1; j < NSTAGE; j++) begin
                slot_d[j] = slot_q[j-1];
            end
            if (stall || flush) begin
                slot_d[0] = '0;
            end else begin
                slot_d[0].valid = id_valid;
                slot_d[0].wr    = id_valid && id_regwrite && (id_dst != '0);
                slot_d[0].load  = id_valid && id_is_load;
                slot_d[0].dst   = tag_t'(id_dst);
                for (int unsigned k = 0; k < NUM_SRC; k++) begin
                    src_d[k] = id_tag[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '{default: '0};
            src_q  <= '{default: '0};
        end else begin
            slot_q <= slot_d;
            src_q  <= src_d;
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
        fwd_match #(
            .NSTAGE     (NSTAGE),
            .LOAD_READY (LOAD_READY),
            .SEL_W      (SEL_W)
        ) u_match (
            .src_i   (src_q[k]),
            .slots_i (slot_q),
            .sel_o   (fwd_sel[k*SEL_W +: SEL_W])
        );
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (stall && !hold) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU, sitting between ID and the EX-stage ALU operand muxes. Unlike a purely combinational comparator, it keeps its own scoreboard of in-flight destination tags, one slot per post-ID stage. It registers the source tags of the instruction entering EX and drives per-operand forward selects. It also detects load-use hazards, inserts bubbles, and honours pipeline-wide freeze and flush.

## Interface
Parameters:
- `NUM_SRC`, 2: source operands per instruction.
- `REG_AW`, 5: register address width.
- `NSTAGE`, 3: tracked stages after ID; slot 0 = EX, slot 1 = MEM, slot `NSTAGE-1` = WB.
- `LOAD_READY`, 2: lowest slot index from which load data is forwardable; legal range 1..`NSTAGE-1`.
- `SEL_W`, `$clog2(NSTAGE)`: derived width of one forward select; not to be overridden.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: synchronous active-low reset, sampled on rising `clk`. One clock; reset is synchronous and active-low.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_src`, in, `NUM_SRC*REG_AW`: ID source tags, packed, operand 0 in LSBs.
- `id_dst`, in, `REG_AW`: ID destination tag.
- `id_regwrite`, in, 1: ID instruction writes `id_dst`.
- `id_is_load`, in, 1: ID instruction is a load.
- `hold`, in, 1: global freeze from the memory system.
- `flush`, in, 1: squash the instruction advancing into EX (branch redirect).
- `stall`, out, 1: load-use hazard. ID and IF must hold; a bubble enters EX.
- `fwd_sel`, out, `NUM_SRC*SEL_W`: per EX operand select. 0 = register-file value, j = result held in slot j (1..`NSTAGE-1`).
- `perf_stall_cnt`, out, 32: load-use stall cycles; present only with `FWD_PERF_CNT_EN`.

## Operation
- Each slot holds: `valid`, `wr` (= regwrite and dst != 0), `dst`, `load`. Slot 0 additionally holds the registered `NUM_SRC` source tags of the EX instruction.
- Advance (`hold`=0): slot j+1 <= slot j; slot `NSTAGE-1` contents retire.
- Slot 0 loads a bubble (valid=0, wr=0) when `stall` or `flush` is high. Otherwise it loads the ID fields qualified by `id_valid`.
- `hold`=1: no slot changes. `flush` and the stall count are ignored that cycle. The flush source keeps `flush` asserted until `hold` drops.
- Hazard: `stall` = `id_valid` and some `id_src[k]` equals slot j `dst`, with slot j valid, wr and load, for some j < `LOAD_READY`-1. Tag 0 never matches.
- Forwarding: for each operand k, `fwd_sel[k]` = smallest j in 1..`NSTAGE-1` where slot j is valid and wr and its dst equals the slot-0 source k. The youngest producer wins. Result is 0 if there is no match or if slot 0 is invalid.
- A load in slot j < `LOAD_READY` is never selected. The stall rule guarantees this never coincides with a match.
- The register file is write-before-read, so a producer retiring from WB needs no ID-side forwarding.

## Timing
- `fwd_sel` and `stall` are combinational from registered state and ID inputs; no added latency. `fwd_sel` is valid in the same cycle the instruction is in EX.
- With default parameters, a load immediately followed by a dependent instruction gives exactly one `stall` cycle. The dependent instruction enters EX with `fwd_sel`=2.
- `stall` persists, with a bubble inserted each non-hold cycle, until the load reaches slot `LOAD_READY`-1.
- Reset: all slots invalid, `stall`=0, all `fwd_sel`=0, `perf_stall_cnt`=0. Reset mid-stall drops `stall` the next cycle.
- `stall` and `flush` together: a single bubble enters slot 0; the count still increments.

## Configuration
- `FWD_PERF_CNT_EN` defined: a 32-bit counter increments on each cycle with `stall`=1 and `hold`=0. It wraps at 2^32-1 to 0, clears on reset, and drives `perf_stall_cnt`.
- Not defined: the port and the counter are absent.

## Structure
- Shared package `cpu_pkg`: the slot record typedef (valid, wr, load, dst), the `FWD_SEL_RF`=0 constant, and the default `REG_AW`.
- One sub-module `fwd_match`: a combinational priority encoder for a single operand (tag vs `NSTAGE-1` slots to `SEL_W` select). It is instantiated `NUM_SRC` times via generate.

## Test plan
- Defaults. `add r3` then `sub r5,r3,r4` back to back -> cycle 2: `fwd_sel[0]`=1, `fwd_sel[1]`=0, `stall`=0.
- `lw r3` then `add r6,r3,r3` -> one `stall` cycle, bubble in EX; next cycle both `fwd_sel`=2; `perf_stall_cnt`=1.
- `add r3`, `add r3`, `or r7,r3,r0` -> `fwd_sel[0]`=1 (youngest); operand r0 -> 0 even when a writer to r0 is in flight.
- `lw r8` in EX with `hold`=1 for 3 cycles and dependent instruction in ID -> `stall` stays 1 and slots are frozen; counter unchanged until `hold`=0.
- `flush` with valid ID `add r9` -> slot 0 invalid next cycle; a following `sub r1,r9,r9` gets `fwd_sel`=0.
- `NSTAGE`=4, `LOAD_READY`=3: `lw r2` then dependent instruction -> 2 stall cycles, then `fwd_sel`=3; reset asserted mid-stall -> `stall`=0 the next cycle.
